// File: rtl/alu_op_sequencer.sv
// Hardwired T-step control FSM for the single-bus datapath: fetch with memory-ready wait and
// timeout, then execute three-register ALU instructions with illegal-opcode trapping.
module alu_op_sequencer #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned RF_W        = 4,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         IR_q,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zlowout,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                fault
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT1w, StT2, StT3, StT4, StT5, StFault
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       fault_q, fault_d;

    logic [4:0]      opcode;
    logic [RF_W-1:0] ra, rb, rc;
    logic            regs_ok;
    logic            legal;
    logic            unused_ir;

    assign opcode    = IR_q[31:27];
    assign ra        = IR_q[26 -: RF_W];
    assign rb        = IR_q[22 -: RF_W];
    assign rc        = IR_q[18 -: RF_W];
    assign unused_ir = ^IR_q[14:0];

    // Index range only needs checking when the field can name a register that does not exist.
    if (NUM_REGS < (1 << RF_W)) begin : g_reg_check
        assign regs_ok = (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) && (32'(rc) < NUM_REGS);
    end else begin : g_reg_nocheck
        assign regs_ok = 1'b1;
    end

    assign legal = (opcode <= 5'd8) && regs_ok;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StIdle;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        Rin       = '0;
        Rout      = '0;
        PCin      = 1'b0;
        PCout     = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zlowout   = 1'b0;
        ALUop     = '0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d   = StT0;
                    illegal_d = 1'b0;
                end
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_d = StT2;
                end else begin
                    state_d = StT1w;
                    wait_d  = 8'd1;
                end
            end
            StT1w: begin
                // PC was already reloaded in T1; only keep the read open.
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    state_d = StT2;
                end else if (wait_q == 8'(MEM_TIMEOUT)) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                if (legal) begin
                    Rout    = NUM_REGS'(1) << rb;
                    Yin     = 1'b1;
                    state_d = StT4;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StT4: begin
                Rout    = NUM_REGS'(1) << rc;
                ALUop   = opcode[ALUOP_W-1:0];
                Zlowin  = 1'b1;
                state_d = StT5;
            end
            StT5: begin
                Zlowout = 1'b1;
                Rin     = NUM_REGS'(1) << ra;
                done    = 1'b1;
                if (run) begin
                    state_d   = StT0;
                    illegal_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle) && (state_q != StFault);
    assign illegal = illegal_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural datapath/memory environment, a per-instruction
// expected-output trace model checked every cycle, and literal checks on the results.
module tb_alu_op_sequencer;

    localparam int MEM_TO = 15;

    localparam logic [10:0] M_PCIN   = 11'h400;
    localparam logic [10:0] M_PCOUT  = 11'h200;
    localparam logic [10:0] M_INCPC  = 11'h100;
    localparam logic [10:0] M_MARIN  = 11'h080;
    localparam logic [10:0] M_READ   = 11'h040;
    localparam logic [10:0] M_MDRIN  = 11'h020;
    localparam logic [10:0] M_MDROUT = 11'h010;
    localparam logic [10:0] M_IRIN   = 11'h008;
    localparam logic [10:0] M_YIN    = 11'h004;
    localparam logic [10:0] M_ZIN    = 11'h002;
    localparam logic [10:0] M_ZOUT   = 11'h001;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] IR_q;
    logic [15:0] Rin, Rout;
    logic        PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout;
    logic [3:0]  ALUop;
    logic        busy, done, illegal, fault;

    alu_op_sequencer #(
        .NUM_REGS(16), .RF_W(4), .ALUOP_W(4), .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR_q(IR_q),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zlowout(Zlowout), .ALUop(ALUop), .busy(busy), .done(done),
        .illegal(illegal), .fault(fault)
    );

    always #5 clock = ~clock;

    // ---------------- datapath and memory environment ----------------
    logic [31:0] R [16];
    logic [31:0] mem [16];
    logic [31:0] PC, MAR, MDR, IR, Y, Z, bus;
    logic        dp_init;
    int          waits;
    int          rd_cnt;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [4:0] n;
        n = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a >> n;
            4'd5:    return $unsigned($signed(a) >>> n);
            4'd6:    return (a << n) | (a >> (6'd32 - {1'b0, n}));
            4'd7:    return a << n;
            4'd8:    return (a >> n) | (a << (6'd32 - {1'b0, n}));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] init_reg(input int i);
        case (i)
            0:       return 32'h34;
            2:       return 32'd5;
            3:       return 32'd7;
            4:       return 32'd2;
            6:       return 32'd9;
            8:       return 32'hAA;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        bus = '0;
        if (PCout)   bus = PC;
        if (Zlowout) bus = Z;
        if (MDRout)  bus = MDR;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus = R[i];
    end

    always @(posedge clock) begin
        if (dp_init) begin
            for (int i = 0; i < 16; i++) R[i] <= init_reg(i);
            PC <= '0; MAR <= '0; MDR <= '0; IR <= '0; Y <= '0; Z <= '0;
        end else begin
            if (MARin)  MAR <= bus;
            if (MDRin)  MDR <= mem[MAR[3:0]];
            if (IRin)   IR  <= bus;
            if (Yin)    Y   <= bus;
            if (PCin)   PC  <= bus;
            if (Zlowin) Z   <= IncPC ? bus + 32'd1 : alu(ALUop, Y, bus);
            for (int i = 0; i < 16; i++) if (Rin[i]) R[i] <= bus;
        end
        rd_cnt <= Read ? rd_cnt + 1 : 0;
    end

    assign IR_q      = IR;
    assign mem_ready = Read && (rd_cnt >= waits);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int done_prev = 0;
    logic [15:0] done_rin = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done) begin
            done_prev <= done_cyc;
            done_cyc  <= cyc;
            done_rin  <= Rin;
        end
    end

    // ---------------- expected-output model ----------------
    typedef struct {
        logic [50:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    logic exp_illegal = 1'b0;

    function automatic logic [50:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [10:0] str, input logic [3:0] op,
                                       input logic b, input logic d, input logic il,
                                       input logic f);
        return {rin, rout, str, op, b, d, il, f};
    endfunction

    task automatic push(input string tag, input logic [50:0] v);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        push("idle", mk('0, '0, '0, '0, 1'b0, 1'b0, exp_illegal, 1'b0));
    endtask

    // Expected cycle-by-cycle outputs of one instruction from T0 onward.
    task automatic push_instr(input logic [31:0] ir, input int w, input bit last, input bit cut);
        logic [4:0]  op;
        logic [15:0] oh_a, oh_b, oh_c;
        op   = ir[31:27];
        oh_a = 16'd1 << ir[26:23];
        oh_b = 16'd1 << ir[22:19];
        oh_c = 16'd1 << ir[18:15];
        exp_illegal = 1'b0;
        push("T0", mk('0, '0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        push("T1", mk('0, '0, M_ZOUT | M_PCIN | M_READ | M_MDRIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        if (w > MEM_TO) begin
            for (int i = 0; i < MEM_TO; i++)
                push("T1W", mk('0, '0, M_READ | M_MDRIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < 3; i++)
                push("FAULT", mk('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1));
            return;
        end
        for (int i = 0; i < w; i++)
            push("T1W", mk('0, '0, M_READ | M_MDRIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        push("T2", mk('0, '0, M_MDROUT | M_IRIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        if (op > 5'd8) begin
            push("T3ill", mk('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
            exp_illegal = 1'b1;
            push_idle();
            return;
        end
        push("T3", mk('0, oh_b, M_YIN, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        push("T4", mk('0, oh_c, M_ZIN, op[3:0], 1'b1, 1'b0, 1'b0, 1'b0));
        if (cut) return;
        push("T5", mk(oh_a, '0, M_ZOUT, '0, 1'b1, 1'b1, 1'b0, 1'b0));
        if (last) push_idle();
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, 64'({Rin, Rout, PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin,
                              Yin, Zlowin, Zlowout, ALUop, busy, done, illegal, fault}),
                  64'(e.v));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            step();
            g++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    initial begin
        int start;
        clear   = 1'b1;
        run     = 1'b0;
        dp_init = 1'b1;
        waits   = 0;
        rd_cnt  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0] = enc(5'h07, 4'd7, 4'd0, 4'd4);
        mem[1] = enc(5'h07, 4'd9, 4'd0, 4'd4);
        mem[2] = enc(5'h00, 4'd1, 4'd2, 4'd3);
        mem[3] = enc(5'h1F, 4'd1, 4'd2, 4'd3);
        mem[4] = enc(5'h00, 4'd1, 4'd2, 4'd3);
        mem[5] = enc(5'h00, 4'd6, 4'd6, 4'd6);
        mem[6] = enc(5'h01, 4'd8, 4'd2, 4'd3);

        repeat (3) step();
        push_idle();
        clear   = 1'b0;
        dp_init = 1'b0;
        drain();

        // shl R7 = R0 << R4, memory ready immediately
        start = cyc;
        push_instr(mem[0], 0, 1'b1, 1'b0);
        pulse_run();
        drain();
        check("latency_nowait", 64'(done_cyc - start), 64'd6);
        check("rin_t5", 64'(done_rin), 64'h0080);
        check("r7_shl", 64'(R[7]), 64'hD0);
        check("pc_after_1", 64'(PC), 64'd1);

        // same op into R9 with three wait cycles
        waits = 3;
        start = cyc;
        push_instr(mem[1], 3, 1'b1, 1'b0);
        pulse_run();
        drain();
        check("latency_wait3", 64'(done_cyc - start), 64'd9);
        check("r9_shl", 64'(R[9]), 64'hD0);
        check("pc_after_2", 64'(PC), 64'd2);

        // memory never ready: timeout into FAULT, held until clear
        waits = 1000;
        push_instr(mem[2], 1000, 1'b1, 1'b0);
        pulse_run();
        drain();
        clear = 1'b1;
        push_idle();
        drain();
        clear = 1'b0;
        waits = 0;
        check("r1_no_write_fault", 64'(R[1]), 64'd0);

        // illegal opcode 0x1F traps back to IDLE
        push_instr(mem[3], 0, 1'b1, 1'b0);
        pulse_run();
        push_idle();
        drain();
        check("r1_no_write_illegal", 64'(R[1]), 64'd0);

        // two adds back to back with run held; run drops during the second
        push_instr(mem[4], 0, 1'b0, 1'b0);
        push_instr(mem[5], 0, 1'b1, 1'b0);
        run = 1'b1;
        repeat (8) step();
        run = 1'b0;
        drain();
        check("done_spacing", 64'(done_cyc - done_prev), 64'd6);
        check("r1_add", 64'(R[1]), 64'd12);
        check("r6_self_add", 64'(R[6]), 64'd18);

        // clear while in T4 aborts with no register write
        push_instr(mem[6], 0, 1'b0, 1'b1);
        pulse_run();
        drain();
        clear = 1'b1;
        push_idle();
        drain();
        clear = 1'b0;
        push_idle();
        push_idle();
        drain();
        check("r8_untouched", 64'(R[8]), 64'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardwired control FSM for the single-bus datapath.
- Fetches and executes three-register ALU instructions (add, sub, and, or, shifts, rotates) as timed T-steps.
- Drives the datapath's one-hot register strobes, PC/MAR/MDR/IR/Y/Z enables and ALU opcode.
- Adds a memory-ready wait with timeout, illegal-opcode trapping and continuous run mode. Fetch with a fixed-latency memory cannot express these.

Parameters:
- NUM_REGS, 16, number of general registers; width of Rin/Rout one-hot vectors.
- RF_W, 4, register-field width in instruction; must equal clog2(NUM_REGS).
- ALUOP_W, 4, ALU opcode width.
- MEM_TIMEOUT, 15, max consecutive wait cycles for mem_ready before fault; range 1..255.

Ports:
- clock  in  1  system clock, all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- run  in  1  level; start or continue execution
- mem_ready  in  1  memory read data valid on Mdatain this cycle
- IR_q  in  32  current IR contents; opcode [31:27], Ra (dest) [26:23], Rb [22:19], Rc [18:15]
- Rin  out  NUM_REGS  one-hot register load strobe
- Rout  out  NUM_REGS  one-hot register bus drive
- PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout  out  1 each  datapath strobes
- ALUop  out  ALUOP_W  ALU operation select
- busy  out  1  high in any state other than IDLE/FAULT
- done  out  1  one-cycle pulse in T5
- illegal  out  1  sticky; set on undefined opcode, cleared by clear or next T0
- fault  out  1  sticky; memory timeout, cleared only by clear

Behaviour:
- Reset: clear=1 at an edge forces IDLE, wait counter 0, illegal=0, fault=0. clear overrides everything, including mid-instruction or mid-wait.
- Reset values: all strobes, ALUop and Rin/Rout are 0.
- Outputs are Moore-decoded from the state register plus IR_q fields. Default is 0 in every state; only listed signals are asserted.
- States:
  - IDLE: go to T0 if run=1.
  - T0: PCout, MARin, IncPC, Zlowin. Clears illegal. Go to T1.
  - T1: Zlowout, PCin, Read, MDRin. If mem_ready, go to T2; else go to T1W with counter=1.
  - T1W: Read, MDRin only (PC is not reloaded). If mem_ready, go to T2. Else if counter==MEM_TIMEOUT, go to FAULT. Else counter+1.
  - T2: MDRout, IRin. Go to T3.
  - T3: decode IR_q. For a legal opcode: Rout[Rb], Yin, go to T4. For an illegal opcode: no strobes, set illegal, go to IDLE.
  - T4: Rout[Rc], ALUop=opcode[ALUOP_W-1:0], Zlowin. Go to T5.
  - T5: Zlowout, Rin[Ra], done. Go to T0 if run=1, else IDLE.
  - FAULT: all strobes 0, stay until clear.
- Legal opcodes are 0x00–0x08, mapped one-to-one to ALUop 0..8: add, sub, and, or, shr, shra, rol, shl, ror. Shl is opcode 0x07 / ALUop 7. All other opcodes are illegal.
- Register index fields ≥ NUM_REGS are illegal and trap in T3 like an illegal opcode.
- Rin/Rout are strictly one-hot or zero; never more than one bit set.
- Latency with mem_ready high in T1: 6 cycles T0..T5. Each wait cycle adds 1.
- run dropping mid-instruction does not abort; the instruction completes to T5 and then goes to IDLE.
- Ra==Rb==Rc is legal. The read happens in T3/T4 and the write in T5, so no hazard.

Test Plan:
- R0=0x34, R4=2, IR=opcode 0x07 Ra=7 Rb=0 Rc=4, run=1 pulse, mem_ready=1 -> Rout=0x0001 in T3, Rout=0x0010 with ALUop=7 in T4, Rin=0x0080 and done in T5 (cycle 6); R7=0xD0.
- Same instruction, mem_ready low for 3 cycles after T1 -> T1W held 3 cycles with Read=MDRin=1 and PCin=0; done at cycle 9; PC incremented exactly once.
- mem_ready never asserted, MEM_TIMEOUT=15 -> FAULT entered after 15 T1W cycles, all strobes 0, busy=0, fault=1 until clear.
- IR opcode 0x1F -> illegal=1 after T3, no Yin/Zlowin/Rin asserted, return to IDLE; next T0 clears illegal.
- run held high over two add instructions -> T5 of the first is followed directly by T0, done pulses 6 cycles apart, busy stays high.
- clear asserted during T4 -> next cycle state IDLE, all outputs 0, no Rin pulse ever issued for that instruction.
